// File: rtl/eq_gain_ramp_ctrl.sv
// 8-band EQ gain controller: free-running sample divider plus a gain ramp FSM stepping toward a target vector.
// Optional macro GAIN_RAMP_EN enables stepwise ramping; otherwise a transfer loads the gains directly.
module eq_gain_ramp_ctrl #(
   parameter int         DIV        = 1024,
   parameter int         STEP_TICKS = 16,
   parameter logic [4:0] GAIN_RST   = 5'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   input  logic [39:0] cfg_gain,
   output logic        cfg_ready,
   output logic        sample_tick,
   output logic [39:0] gain,
   output logic        busy,
   output logic        ramp_done
);

   typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] div_cnt;
   logic        xfer;

   // The divider only ever sees rst; configuration never disturbs the sample cadence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if (div_cnt == 16'(DIV - 1))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 16'd1;
   end

   assign sample_tick = (div_cnt == 16'(DIV - 1));
   assign cfg_ready   = (state == IDLE);
   assign busy        = (state == RAMP);
   assign ramp_done   = (state == DONE);
   assign xfer        = cfg_valid && (state == IDLE);

`ifdef GAIN_RAMP_EN
   logic [7:0]  step_cnt;
   logic [39:0] target;
   logic [39:0] step_gain;
   logic        step_stb;

   assign step_stb = (state == RAMP) && sample_tick && (step_cnt == 8'(STEP_TICKS - 1));

   // Each band moves one code toward its own target, so it can never overshoot or wrap.
   always_comb begin
      step_gain = gain;
      for (int i = 0; i < 8; i++) begin
         if (gain[5*i +: 5] < target[5*i +: 5])
            step_gain[5*i +: 5] = gain[5*i +: 5] + 5'd1;
         else if (gain[5*i +: 5] > target[5*i +: 5])
            step_gain[5*i +: 5] = gain[5*i +: 5] - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt <= '0;
         target   <= {8{GAIN_RST}};
         gain     <= {8{GAIN_RST}};
      end else begin
         if (xfer) begin
            step_cnt <= '0;
            target   <= cfg_gain;
         end else if (state == RAMP && sample_tick) begin
            step_cnt <= step_stb ? 8'd0 : step_cnt + 8'd1;
         end
         if (step_stb)
            gain <= step_gain;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gain <= {8{GAIN_RST}};
      else if (xfer)
         gain <= cfg_gain;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (xfer) begin
`ifdef GAIN_RAMP_EN
               state_nxt = (cfg_gain != gain) ? RAMP : DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
         RAMP: begin
`ifdef GAIN_RAMP_EN
            if (step_stb && (step_gain == target))
               state_nxt = DONE;
`else
            state_nxt = IDLE;
`endif
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
